// File: rtl/video_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_vram_arbiter                                              |
// | Purpose  : Owns the PPU cart/VRAM bus and shares it between the render     |
// |            fetch sequencer (priority) and host PPUDATA accesses. Each      |
// |            transaction is IDLE -> RD_WAIT|WR -> DONE -> IDLE.              |
// | Ports    : I_clock/I_reset        clock, synchronous active-high reset     |
// |            I_render_req/addr      level request, held until O_render_ack   |
// |            O_render_ack/data      ack pulse, read data (held)              |
// |            I_host_req/wren/addr/data  one-cycle host access request        |
// |            O_host_busy/done/data  pending flag, done pulse, read data      |
// |            O_cart_addr/wren/data, I_cart_data   cart bus                   |
// | Options  : VIDEO_ARB_STARVE_GUARD_EN - after P_max_wait cycles of waiting  |
// |            the host wins the next grant even if render is requesting.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module video_vram_arbiter #(
  parameter int P_addr_bits  = 14,
  parameter int P_rd_latency = 1,
  parameter int P_max_wait   = 8
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  input  logic                   I_render_req,
  input  logic [P_addr_bits-1:0] I_render_addr,
  output logic                   O_render_ack,
  output logic [7:0]             O_render_data,
  input  logic                   I_host_req,
  input  logic                   I_host_wren,
  input  logic [P_addr_bits-1:0] I_host_addr,
  input  logic [7:0]             I_host_data,
  output logic                   O_host_busy,
  output logic                   O_host_done,
  output logic [7:0]             O_host_data,
  output logic [P_addr_bits-1:0] O_cart_addr,
  output logic                   O_cart_wren,
  input  logic [7:0]             I_cart_data,
  output logic [7:0]             O_cart_data
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR      = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] C_LAT_LAST = 2'(P_rd_latency - 1);
  localparam logic [3:0] C_MAX_WAIT = 4'(P_max_wait);
`ifdef VIDEO_ARB_STARVE_GUARD_EN
  localparam logic C_GUARD_EN = 1'b1;
`else
  localparam logic C_GUARD_EN = 1'b0;
`endif

  logic [1:0]             state_q, state_d;
  logic                   owner_host_q, owner_host_d;
  logic [1:0]             lat_cnt_q, lat_cnt_d;
  logic                   busy_q, busy_d;
  logic                   h_wren_q, h_wren_d;
  logic [P_addr_bits-1:0] h_addr_q, h_addr_d;
  logic [7:0]             h_data_q, h_data_d;
  logic [P_addr_bits-1:0] cart_addr_q, cart_addr_d;
  logic                   cart_wren_q, cart_wren_d;
  logic [7:0]             cart_wdata_q, cart_wdata_d;
  logic [7:0]             render_data_q, render_data_d;
  logic [7:0]             host_data_q, host_data_d;
  logic [3:0]             wait_q, wait_d;

  logic w_idle;
  logic w_starve;
  logic w_host_first;
  logic w_grant_render;
  logic w_grant_host;
  logic w_lat_last;
  logic w_host_done;
  logic w_host_active;
  logic w_busy;

  // The wait counter always runs; it only steers arbitration when the guard
  // is compiled in.
  assign w_starve       = C_GUARD_EN && (wait_q >= C_MAX_WAIT);
  assign w_idle         = (state_q == S_IDLE);
  assign w_host_first   = busy_q && (!I_render_req || w_starve);
  assign w_grant_render = w_idle && I_render_req && !w_host_first;
  assign w_grant_host   = w_idle && w_host_first;
  assign w_lat_last     = (lat_cnt_q == C_LAT_LAST);
  assign w_host_done    = (state_q == S_DONE) && owner_host_q;
  assign w_host_active  = !w_idle && owner_host_q;
  // Busy drops in the DONE cycle so a new host request can be taken there.
  assign w_busy         = busy_q && !w_host_done;

  // State register and datapath flops
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q       <= S_IDLE;
      owner_host_q  <= 1'b0;
      lat_cnt_q     <= '0;
      busy_q        <= 1'b0;
      h_wren_q      <= 1'b0;
      h_addr_q      <= '0;
      h_data_q      <= '0;
      cart_addr_q   <= '0;
      cart_wren_q   <= 1'b0;
      cart_wdata_q  <= '0;
      render_data_q <= '0;
      host_data_q   <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      owner_host_q  <= owner_host_d;
      lat_cnt_q     <= lat_cnt_d;
      busy_q        <= busy_d;
      h_wren_q      <= h_wren_d;
      h_addr_q      <= h_addr_d;
      h_data_q      <= h_data_d;
      cart_addr_q   <= cart_addr_d;
      cart_wren_q   <= cart_wren_d;
      cart_wdata_q  <= cart_wdata_d;
      render_data_q <= render_data_d;
      host_data_q   <= host_data_d;
      wait_q        <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant_render)    state_d = S_RD_WAIT;
        else if (w_grant_host) state_d = h_wren_q ? S_WR : S_RD_WAIT;
      end
      S_RD_WAIT: if (w_lat_last) state_d = S_DONE;
      S_WR:      state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    owner_host_d  = owner_host_q;
    lat_cnt_d     = lat_cnt_q;
    busy_d        = busy_q;
    h_wren_d      = h_wren_q;
    h_addr_d      = h_addr_q;
    h_data_d      = h_data_q;
    cart_addr_d   = cart_addr_q;
    cart_wren_d   = 1'b0;
    cart_wdata_d  = cart_wdata_q;
    render_data_d = render_data_q;
    host_data_d   = host_data_q;
    wait_d        = wait_q;

    if (w_grant_render || w_grant_host) begin
      owner_host_d = w_grant_host;
      lat_cnt_d    = '0;
      cart_addr_d  = w_grant_host ? h_addr_q : I_render_addr;
    end
    // The strobe is registered so it is high exactly during the WR state.
    if (w_grant_host && h_wren_q) begin
      cart_wren_d  = 1'b1;
      cart_wdata_d = h_data_q;
    end

    if (state_q == S_RD_WAIT) begin
      lat_cnt_d = lat_cnt_q + 2'd1;
      if (w_lat_last) begin
        if (owner_host_q) host_data_d   = I_cart_data;
        else              render_data_d = I_cart_data;
      end
    end

    if (w_host_done) busy_d = 1'b0;
    // Capture after the clear so a request in the DONE cycle is kept.
    if (I_host_req && !w_busy) begin
      busy_d   = 1'b1;
      h_wren_d = I_host_wren;
      h_addr_d = I_host_addr;
      h_data_d = I_host_data;
    end

    if (w_grant_host)
      wait_d = '0;
    else if (busy_q && !w_host_active && (wait_q != 4'hF))
      wait_d = wait_q + 4'd1;
  end

  // Outputs; pulses and busy are masked by reset so an aborted transaction
  // never reports completion.
  always_comb begin
    O_render_ack  = !I_reset && (state_q == S_DONE) && !owner_host_q;
    O_host_done   = !I_reset && w_host_done;
    O_host_busy   = !I_reset && w_busy;
    O_render_data = render_data_q;
    O_host_data   = host_data_q;
    O_cart_addr   = cart_addr_q;
    O_cart_wren   = cart_wren_q;
    O_cart_data   = cart_wdata_q;
  end

endmodule
`default_nettype wire
